// File: rtl/alu_seq_muldiv.sv
// Handshaked execute-stage ALU with registered result/flags and optional iterative multiply/divide.
// Define ALU_MULDIV_EN to build the multiply/divide datapath; otherwise ops 10-15 report op_illegal.
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             c,
    output logic             op_illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d, ill_q, ill_d;

    logic [WIDTH:0]          add_sum, sub_sum;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_v, alu_c, alu_ill;
    logic                    go_busy;

    logic             load;
    logic [WIDTH-1:0] new_res;
    logic             new_v, new_c, new_ill;

    assign a_s = a;

    // Single-cycle results are computed on the live request and registered at accept.
    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = b[SHW-1:0];
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = a_s >>> shamt;
            default: begin
`ifdef ALU_MULDIV_EN
                // Only the divide corner cases (b==0, MIN/-1) complete here; op[1] selects REM.
                if (b == '0) begin
                    alu_res = op[1] ? a : '1;
                end else begin
                    alu_res = op[1] ? '0 : a;
                end
`else
                alu_ill = 1'b1;
`endif
            end
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] step_hi, step_lo, md_res;
    logic             is_md, div_short, sgn;

    assign is_md     = (op >= 4'd10);
    assign sgn       = ~op[0];
    assign div_short = op[3] & op[2] & ((b == '0) | (sgn & (a == MOST_NEG) & (b == '1)));
    assign go_busy   = is_md & ~div_short;

    // One iteration: hi/lo hold the running product, or remainder/quotient for divides.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[MSB]};
        div_trial = div_shift - {1'b0, mcand_q};
        if (op_q[2]) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
            if (op_q[1]) begin
                md_res = negr_q ? -step_hi : step_hi;
            end else begin
                md_res = negq_q ? -step_lo : step_lo;
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
            md_res  = op_q[0] ? step_hi : step_lo;
        end
    end
`else
    assign go_busy = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        tag_d    = tag_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        c_d      = c_q;
        ill_d    = ill_q;
        load     = 1'b0;
        new_res  = '0;
        new_v    = 1'b0;
        new_c    = 1'b0;
        new_ill  = 1'b0;
`ifdef ALU_MULDIV_EN
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    tag_d = tag_in;
                    if (go_busy) begin
`ifdef ALU_MULDIV_EN
                        state_d = S_BUSY;
                        op_d    = op;
                        cnt_d   = '0;
                        hi_d    = '0;
                        if (op[2]) begin
                            lo_d    = (sgn && a[MSB]) ? -a : a;
                            mcand_d = (sgn && b[MSB]) ? -b : b;
                            negq_d  = sgn && (a[MSB] ^ b[MSB]);
                            negr_d  = sgn && a[MSB];
                        end else begin
                            lo_d    = b;
                            mcand_d = a;
                            negq_d  = 1'b0;
                            negr_d  = 1'b0;
                        end
`endif
                    end else begin
                        state_d = S_DONE;
                        load    = 1'b1;
                        new_res = alu_res;
                        new_v   = alu_v;
                        new_c   = alu_c;
                        new_ill = alu_ill;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                // The last iteration's result is finalised directly so DONE follows without a bubble.
                if (cnt_q == '1) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                    new_res = md_res;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            result_d = new_res;
            z_d      = (new_res == '0);
            n_d      = new_res[MSB];
            v_d      = new_v;
            c_d      = new_c;
            ill_d    = new_ill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            tag_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            c_q      <= c_d;
            ill_q    <= ill_d;
        end
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end
`endif

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign result     = result_q;
    assign tag_out    = tag_q;
    assign z          = z_q;
    assign n          = n_q;
    assign v          = v_q;
    assign c          = c_q;
    assign op_illegal = ill_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed self-checking bench for alu_seq_muldiv (WIDTH=32); muldiv vectors run when ALU_MULDIV_EN is defined.
module tb_alu_seq_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   tag_in = 4'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [3:0]   tag_out;
    logic         z, n, v, c, op_illegal;

    int errors = 0;
    int checks = 0;

    alu_seq_muldiv #(.WIDTH(W), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out),
        .z(z), .n(n), .v(v), .c(c), .op_illegal(op_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Flags packed as {z,n,v,c,op_illegal}.
    task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [3:0] t, input int exp_lat,
                          input logic [W-1:0] exp_res, input logic [4:0] exp_flags);
        int   lat;
        logic rdy_seen;
        @(negedge clk);
        chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; a = aa; b = bb; tag_in = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
        if (exp_lat > 1) chk({name, ".busy_in_ready"}, 64'(rdy_seen), 64'd0);
        chk({name, ".done_in_ready"}, 64'(in_ready), 64'd0);
        chk({name, ".result"}, 64'(result), 64'(exp_res));
        chk({name, ".tag"}, 64'(tag_out), 64'(t));
        chk({name, ".flags"}, 64'({z, n, v, c, op_illegal}), 64'(exp_flags));
        $display("op=%0d a=%h b=%h tag=%0d -> result=%h flags=%b lat=%0d",
                 o, aa, bb, t, result, {z, n, v, c, op_illegal}, lat);
        @(posedge clk); #1;
        chk({name, ".handoff"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic stable;
        logic quiet;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.result", 64'(result), 64'd0);
        chk("reset.tag", 64'(tag_out), 64'd0);
        chk("reset.flags", 64'({z, n, v, c, op_illegal}), 64'd0);

        run_op("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1, 1, 32'h8000_0000, 5'b01100);
        run_op("sub_zero", 4'd1, 32'd5,         32'd5,         4'd2, 1, 32'h0000_0000, 5'b10010);
        run_op("sra",      4'd9, 32'h8000_0000, 32'd31,        4'd3, 1, 32'hFFFF_FFFF, 5'b01000);
        run_op("sltu",     4'd5, 32'd1,         32'hFFFF_FFFF, 4'd4, 1, 32'h0000_0001, 5'b00000);
        run_op("slt",      4'd4, 32'hFFFF_FFFF, 32'd1,         4'd5, 1, 32'h0000_0001, 5'b00000);
        run_op("xor",      4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 1, 32'h0FF0_0FF0, 5'b00000);
        run_op("and",      4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd7, 1, 32'h0F00_0F00, 5'b00000);
        run_op("or",       4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd8, 1, 32'hFFF0_FFF0, 5'b01000);
        run_op("sll_mask", 4'd7, 32'd1,         32'h0000_0024, 4'd9, 1, 32'h0000_0010, 5'b00000);
        run_op("srl",      4'd8, 32'h8000_0000, 32'd4,         4'hA, 1, 32'h0800_0000, 5'b00000);
        run_op("add_carry",4'd0, 32'hFFFF_FFFF, 32'd1,         4'hB, 1, 32'h0000_0000, 5'b10010);
        run_op("sub_borrow",4'd1,32'd0,         32'd1,         4'hC, 1, 32'hFFFF_FFFF, 5'b01000);
        run_op("sub_ovf",  4'd1, 32'h8000_0000, 32'd1,         4'hD, 1, 32'h7FFF_FFFF, 5'b00110);

`ifdef ALU_MULDIV_EN
        run_op("mul",      4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 33, 32'h0000_0001, 5'b00000);
        run_op("mulhu",    4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 33, 32'hFFFF_FFFE, 5'b01000);
        run_op("mul_small",4'd10, 32'd3,         32'd5,         4'd3, 33, 32'd15,         5'b00000);
        run_op("div_neg",  4'd12, 32'hFFFF_FFF9, 32'd2,         4'd4, 33, 32'hFFFF_FFFD, 5'b01000);
        run_op("rem_neg",  4'd14, 32'hFFFF_FFF9, 32'd2,         4'd5, 33, 32'hFFFF_FFFF, 5'b01000);
        run_op("rem_pos",  4'd14, 32'd7,         32'hFFFF_FFFE, 4'd6, 33, 32'h0000_0001, 5'b00000);
        run_op("divu",     4'd13, 32'd100,       32'd7,         4'd7, 33, 32'd14,         5'b00000);
        run_op("remu",     4'd15, 32'd100,       32'd7,         4'd8, 33, 32'd2,          5'b00000);
        run_op("divu_dz",  4'd13, 32'd100,       32'd0,         4'd9, 1,  32'hFFFF_FFFF, 5'b01000);
        run_op("remu_dz",  4'd15, 32'd100,       32'd0,         4'hA, 1,  32'd100,        5'b00000);
        run_op("rem_ovf",  4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 4'hB, 1,  32'h0000_0000, 5'b10000);
        run_op("div_ovf",  4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 4'hC, 1,  32'h8000_0000, 5'b01000);
`else
        run_op("div_ill",  4'd12, 32'd7,         32'd2,         4'd1, 1,  32'h0000_0000, 5'b10001);
        run_op("mul_ill",  4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 1,  32'h0000_0000, 5'b10001);
        run_op("add_after",4'd0,  32'd1,         32'd2,         4'd3, 1,  32'd3,          5'b00000);
`endif

        // Backpressure: response held while a new request waits at the input.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4; tag_in = 4'd9;
        @(posedge clk); #1;
        op = 4'd1; a = 32'd10; b = 32'd1; tag_in = 4'hA;
        chk("bp.out_valid", 64'(out_valid), 64'd1);
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!(out_valid && !in_ready && result == 32'd7 && tag_out == 4'd9)) stable = 1'b0;
        end
        chk("bp.stable", 64'(stable), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.handoff_valid", 64'(out_valid), 64'd0);
        chk("bp.handoff_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.next_valid", 64'(out_valid), 64'd1);
        chk("bp.next_result", 64'(result), 64'd9);
        chk("bp.next_tag", 64'(tag_out), 64'hA);
        $display("backpressure: held result=7 tag=9 stable=%0b, next result=%h tag=%0d", stable, result, tag_out);
        @(posedge clk); #1;

        // Reset while a response is pending in DONE.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 32'hFFFF_FFFF; b = 32'd5; tag_in = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rst_done.out_valid", 64'(out_valid), 64'd0);
        chk("rst_done.result", 64'(result), 64'd0);
        chk("rst_done.tag", 64'(tag_out), 64'd0);
        chk("rst_done.flags", 64'({z, n, v, c, op_illegal}), 64'd0);
        $display("reset in DONE: out_valid=%0b result=%h", out_valid, result);

`ifdef ALU_MULDIV_EN
        // Reset mid-iteration aborts the multiply; no response follows.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd10; a = 32'd6; b = 32'd7; tag_in = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy.in_ready", 64'(in_ready), 64'd1);
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) quiet = 1'b0;
        end
        chk("rst_busy.quiet", 64'(quiet), 64'd1);
        chk("rst_busy.result", 64'(result), 64'd0);
        $display("reset in BUSY: response suppressed=%0b", quiet);
        run_op("after_rst_mul", 4'd10, 32'd6, 32'd7, 4'd2, 33, 32'd42, 5'b00000);
`else
        quiet = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) quiet = 1'b0;
        end
        chk("rst_done.quiet", 64'(quiet), 64'd1);
`endif
        run_op("after_rst_add", 4'd0, 32'd2, 32'd3, 4'd4, 1, 32'd5, 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
